shift_stage_l: RTL and testbench
================================

# shift_stage_l

Registered, handshaked execution stage wrapped around the combinational `polyshift_l` left shifter. It accepts shift requests over valid/ready, computes the result in the same cycle, and holds results in a two-entry skid buffer so `ready_o` is a registered signal. It also supports multi-word (double-precision) shifts by chaining the previous word's upper bits into the `RCL` fill input. The block sits between operand issue and the ALU writeback mux.

## Interface
- `WORD_WIDTH`, default 8: data word width. Must be a power of two and at least 4.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. Synchronous and active-high.
- `valid_i` in 1: request valid.
- `ready_o` out 1: request accepted when `valid_i && ready_o` at the rising edge.
- `d_i` in `WORD_WIDTH`: operand word.
- `c_i` in `WORD_WIDTH-1`: explicit fill bits for `RCL`. Used only when `first_i=1`.
- `first_i` in 1: 1 selects `c_i` as fill; 0 selects the chain register.
- `shift_size_i` in `$clog2(WORD_WIDTH)`: shift amount, 0..`WORD_WIDTH-1`.
- `shift_type_i` in `SHIFT_TYPE`: `LOGIC`=0, `ARITH`=1, `RCL`=2, `ROL`=3.
- `valid_o` out 1: result valid.
- `ready_i` in 1: result consumed when `valid_o && ready_i` at the rising edge.
- `d_o` out `WORD_WIDTH`: shift result.
- `flags_o` out `shift_flags_t` {cf, zf, sf}: result flags.

## Operation
- Result functions, with W = `WORD_WIDTH` and s = shift size:
  - `LOGIC` and `ARITH`: d<<s.
  - `ROL`: rotate d left by s.
  - `RCL`: upper W bits of {d, fill, 1'b0}<<s.
- The result is computed combinationally from the request by `polyshift_l` and written into the skid buffer on acceptance.
- Chain register (W-1 bits):
  - Loads `d_i[W-1:1]` on every accepted request, for all shift types.
  - The fill for the next request with `first_i=0` is the chain register.
  - The chain register is not affected by output-side events.
- Flags:
  - cf: last bit shifted out, `d_i[W-s]`; 0 when s=0. For `ROL`, cf equals result bit 0 (0 when s=0).
  - zf: 1 when result==0.
  - sf: result[W-1].
- Skid buffer: two entries, FIFO order.
  - Output is entry head.
  - `valid_o` = count≠0.
  - `ready_o` is registered, = (next count < 2).
  - Accept and consume in the same cycle keeps count unchanged; the data shifts correctly.
- Full (count=2): `ready_o`=0. `valid_i` is ignored, and the chain register does not update.
- Empty (count=0): `valid_o`=0. `d_o` and `flags_o` hold their last value.
- Reset values: `valid_o`=0, `ready_o`=1, `d_o`=0, `flags_o`=0, chain=0, count=0.
- Reset mid-operation discards all buffered results. Requests presented during `rst_i` are not accepted.

## Timing
- Latency is 1 cycle. A request accepted at edge T shows `valid_o`=1 after T, provided the buffer was empty.
- Throughput is one request per cycle while `ready_i`=1.
- `ready_o` depends only on flops. There is no combinational path from `ready_i` to `ready_o`.
- `d_o`, `flags_o`, and `valid_o` are driven from flops.
- After `ready_i` drops, at most one further request is accepted before `ready_o` falls.

## Configuration
- `SHIFT_STAGE_FLAGS_EN` defined: flag logic and flag storage are present in both skid entries.
- `SHIFT_STAGE_FLAGS_EN` undefined: `flags_o` is tied to 0 and no flag flops exist. All other behaviour and timing are identical.

## Structure
- Shared package: `SHIFT_TYPE` (existing) and the new packed struct `shift_flags_t` {cf, zf, sf}.
- Sub-modules:
  - Reuses the existing `polyshift_l` instance.
  - One new sub-module, `pipe_skid #(WIDTH)`: a generic two-entry registered-ready buffer that carries {`d_o`, `flags_o`}.
- The chain register and flag computation live in `shift_stage_l`.

## Test plan
All cases use W=8 with `ready_i`=1 unless stated.
- `LOGIC`, d=8'hB1, s=3 → d_o=8'h88, cf=1, zf=0, sf=1, one cycle after accept.
- `ROL`, d=8'h81, s=1 → d_o=8'h03, cf=1. Same d with s=0 → d_o=8'h81, cf=0.
- `RCL`, `first_i`=1, d=8'h01, c=7'b1110000, s=2 → d_o=8'h07.
- Chain sequence:
  - `RCL` d=8'hF0, `first_i`=1, c=0, s=4 → d_o=8'h00, zf=1, cf=1.
  - Next request `RCL` d=8'h12, `first_i`=0, s=4 → d_o=8'h2F.
- Backpressure:
  - With `ready_i`=0, present 3 back-to-back requests → exactly 2 accepted, and `ready_o`=0 after the second.
  - Then raise `ready_i` → both results emerge in order with no duplicates, and `ready_o` returns to 1.
- Reset mid-stream: assert `rst_i` with count=2 → next cycle `valid_o`=0, `ready_o`=1, chain=0. A following `RCL` with `first_i`=0 uses zero fill.

Source files
------------

// File: rtl/shift_stage_l_pkg.sv
// Shared types for the shift execution stage: shift opcode and result flags.
package shift_stage_l_pkg;

    typedef enum logic [1:0] {
        LOGIC = 2'd0,
        ARITH = 2'd1,
        RCL   = 2'd2,
        ROL   = 2'd3
    } SHIFT_TYPE;

    typedef struct packed {
        logic cf;
        logic zf;
        logic sf;
    } shift_flags_t;

    localparam int FLAGS_WIDTH = $bits(shift_flags_t);

endpackage

// File: rtl/shift_stage_l_if.sv
// Request/result handshake bundle for shift_stage_l; slave is the stage side.
interface shift_stage_l_if
    import shift_stage_l_pkg::*;
#(
    parameter int WORD_WIDTH = 8
) ();

    logic                          valid_i;
    logic                          ready_o;
    logic [WORD_WIDTH-1:0]         d_i;
    logic [WORD_WIDTH-2:0]         c_i;
    logic                          first_i;
    logic [$clog2(WORD_WIDTH)-1:0] shift_size_i;
    SHIFT_TYPE                     shift_type_i;
    logic                          valid_o;
    logic                          ready_i;
    logic [WORD_WIDTH-1:0]         d_o;
    shift_flags_t                  flags_o;

    modport slave (
        input  valid_i, d_i, c_i, first_i, shift_size_i, shift_type_i, ready_i,
        output ready_o, valid_o, d_o, flags_o
    );

    modport master (
        output valid_i, d_i, c_i, first_i, shift_size_i, shift_type_i, ready_i,
        input  ready_o, valid_o, d_o, flags_o
    );

endinterface

// File: rtl/pipe_skid.sv
// Generic two-entry FIFO skid buffer with a registered input-side ready.
module pipe_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             push;
    logic             pop;

    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Head keeps its old value when drained so the output holds while empty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= 2'd0;
            in_ready <= 1'b1;
        end else begin
            count_q  <= count_d;
            in_ready <= (count_d != 2'd2);
            if (pop) begin
                if (count_q == 2'd2)
                    head_q <= tail_q;
                else if (push)
                    head_q <= in_data;
            end else if (push) begin
                if (count_q == 2'd0)
                    head_q <= in_data;
                else
                    tail_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/polyshift_l.sv
// Combinational left shifter: logical/arithmetic shift, rotate, and rotate
// through an externally supplied fill word (RCL).
module polyshift_l
    import shift_stage_l_pkg::*;
#(
    parameter int WORD_WIDTH = 8
) (
    input  logic [WORD_WIDTH-1:0]         d_i,
    input  logic [WORD_WIDTH-2:0]         fill_i,
    input  logic [$clog2(WORD_WIDTH)-1:0] shift_size_i,
    input  SHIFT_TYPE                     shift_type_i,
    output logic [WORD_WIDTH-1:0]         d_o
);

    logic [2*WORD_WIDTH-1:0] wide;
    logic [2*WORD_WIDTH-1:0] shifted;

    // Every mode is the upper half of a double-width vector shifted left;
    // only the lower half (what gets pulled in) differs between modes.
    always_comb begin
        wide = {d_i, {WORD_WIDTH{1'b0}}};
        case (shift_type_i)
            RCL:     wide = {d_i, fill_i, 1'b0};
            ROL:     wide = {d_i, d_i};
            default: wide = {d_i, {WORD_WIDTH{1'b0}}};
        endcase
        shifted = wide << shift_size_i;
        d_o     = shifted[2*WORD_WIDTH-1:WORD_WIDTH];
    end

endmodule

// File: rtl/shift_stage_l.sv
// Registered, handshaked shift stage with RCL word chaining and a skid buffer.
// Define SHIFT_STAGE_FLAGS_EN to compute and store the cf/zf/sf result flags.
module shift_stage_l
    import shift_stage_l_pkg::*;
#(
    parameter int WORD_WIDTH = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    shift_stage_l_if.slave  bus
);

    logic [WORD_WIDTH-2:0] chain_q;
    logic [WORD_WIDTH-2:0] fill;
    logic [WORD_WIDTH-1:0] result;
    logic                  accept;

    assign fill   = bus.first_i ? bus.c_i : chain_q;
    assign accept = bus.valid_i & bus.ready_o;

    polyshift_l #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_polyshift (
        .d_i          (bus.d_i),
        .fill_i       (fill),
        .shift_size_i (bus.shift_size_i),
        .shift_type_i (bus.shift_type_i),
        .d_o          (result)
    );

    // The upper bits of each accepted word become the RCL fill of the next one.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            chain_q <= '0;
        else if (accept)
            chain_q <= bus.d_i[WORD_WIDTH-1:1];
    end

`ifdef SHIFT_STAGE_FLAGS_EN
    localparam int SKID_WIDTH = WORD_WIDTH + FLAGS_WIDTH;

    logic [WORD_WIDTH:0]   spill;
    shift_flags_t          flags;
    logic [SKID_WIDTH-1:0] skid_out;

    // Bit W of the widened shift is the last bit pushed out; zero when s=0.
    assign spill    = {1'b0, bus.d_i} << bus.shift_size_i;
    assign flags.cf = spill[WORD_WIDTH];
    assign flags.zf = (result == '0);
    assign flags.sf = result[WORD_WIDTH-1];

    assign bus.d_o     = skid_out[SKID_WIDTH-1:FLAGS_WIDTH];
    assign bus.flags_o = shift_flags_t'(skid_out[FLAGS_WIDTH-1:0]);

    pipe_skid #(
        .WIDTH (SKID_WIDTH)
    ) u_skid (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_valid  (bus.valid_i),
        .in_ready  (bus.ready_o),
        .in_data   ({result, flags}),
        .out_valid (bus.valid_o),
        .out_ready (bus.ready_i),
        .out_data  (skid_out)
    );
`else
    assign bus.flags_o = '0;

    pipe_skid #(
        .WIDTH (WORD_WIDTH)
    ) u_skid (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_valid  (bus.valid_i),
        .in_ready  (bus.ready_o),
        .in_data   (result),
        .out_valid (bus.valid_o),
        .out_ready (bus.ready_i),
        .out_data  (bus.d_o)
    );
`endif

endmodule

// File: tb/tb_shift_stage_l.sv
// Directed self-checking bench for shift_stage_l at WORD_WIDTH=8.
module tb_shift_stage_l;
    import shift_stage_l_pkg::*;

    logic clk_i;
    logic rst_i;
    int   checks;
    int   errors;

    shift_stage_l_if #(.WORD_WIDTH(8)) bus ();

    shift_stage_l #(
        .WORD_WIDTH (8)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Expected flag value; the stage ties flags to zero when they are compiled out.
    function automatic logic [31:0] exp_flags(input logic cf, input logic zf, input logic sf);
`ifdef SHIFT_STAGE_FLAGS_EN
        return {29'd0, cf, zf, sf};
`else
        return 32'd0 & {29'd0, cf, zf, sf};
`endif
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Presents one request from a falling edge and returns at the next one.
    task automatic apply_stimulus(input SHIFT_TYPE kind, input logic [7:0] d,
                                  input logic [6:0] c, input logic first,
                                  input logic [2:0] s);
        bus.valid_i      = 1'b1;
        bus.shift_type_i = kind;
        bus.d_i          = d;
        bus.c_i          = c;
        bus.first_i      = first;
        bus.shift_size_i = s;
        @(negedge clk_i);
    endtask

    task automatic idle_cycle();
        bus.valid_i = 1'b0;
        @(negedge clk_i);
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst_i            = 1'b1;
        bus.valid_i      = 1'b0;
        bus.ready_i      = 1'b1;
        bus.d_i          = '0;
        bus.c_i          = '0;
        bus.first_i      = 1'b1;
        bus.shift_size_i = '0;
        bus.shift_type_i = LOGIC;
        @(negedge clk_i);
        @(negedge clk_i);

        check_output("reset_valid", 32'(bus.valid_o), 32'd0);
        check_output("reset_ready", 32'(bus.ready_o), 32'd1);
        check_output("reset_d", 32'(bus.d_o), 32'd0);
        check_output("reset_flags", 32'(bus.flags_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        $display("[TB] basic shift modes");
        apply_stimulus(LOGIC, 8'hB1, 7'h00, 1'b1, 3'd3);
        check_output("logic_valid", 32'(bus.valid_o), 32'd1);
        check_output("logic_d", 32'(bus.d_o), 32'h88);
        check_output("logic_flags", 32'(bus.flags_o), exp_flags(1'b1, 1'b0, 1'b1));
        idle_cycle();
        check_output("empty_valid", 32'(bus.valid_o), 32'd0);
        check_output("empty_hold_d", 32'(bus.d_o), 32'h88);

        apply_stimulus(ROL, 8'h81, 7'h00, 1'b1, 3'd1);
        check_output("rol1_d", 32'(bus.d_o), 32'h03);
        check_output("rol1_flags", 32'(bus.flags_o), exp_flags(1'b1, 1'b0, 1'b0));
        apply_stimulus(ROL, 8'h81, 7'h00, 1'b1, 3'd0);
        check_output("rol0_d", 32'(bus.d_o), 32'h81);
        check_output("rol0_flags", 32'(bus.flags_o), exp_flags(1'b0, 1'b0, 1'b1));
        apply_stimulus(RCL, 8'h01, 7'b1110000, 1'b1, 3'd2);
        check_output("rcl_first_d", 32'(bus.d_o), 32'h07);
        check_output("rcl_first_flags", 32'(bus.flags_o), exp_flags(1'b0, 1'b0, 1'b0));

        $display("[TB] chained RCL, back to back");
        apply_stimulus(RCL, 8'hF0, 7'h00, 1'b1, 3'd4);
        check_output("chain0_d", 32'(bus.d_o), 32'h00);
        check_output("chain0_flags", 32'(bus.flags_o), exp_flags(1'b1, 1'b1, 1'b0));
        apply_stimulus(RCL, 8'h12, 7'h00, 1'b0, 3'd4);
        check_output("chain1_valid", 32'(bus.valid_o), 32'd1);
        check_output("chain1_d", 32'(bus.d_o), 32'h2F);
        check_output("chain1_flags", 32'(bus.flags_o), exp_flags(1'b1, 1'b0, 1'b0));
        idle_cycle();

        $display("[TB] backpressure");
        bus.ready_i = 1'b0;
        apply_stimulus(LOGIC, 8'h03, 7'h00, 1'b1, 3'd1);
        check_output("bp_a_ready", 32'(bus.ready_o), 32'd1);
        check_output("bp_a_d", 32'(bus.d_o), 32'h06);
        apply_stimulus(LOGIC, 8'h05, 7'h00, 1'b1, 3'd1);
        check_output("bp_full_ready", 32'(bus.ready_o), 32'd0);
        check_output("bp_full_d", 32'(bus.d_o), 32'h06);
        apply_stimulus(LOGIC, 8'hFF, 7'h00, 1'b1, 3'd1);
        check_output("bp_ignored_ready", 32'(bus.ready_o), 32'd0);
        check_output("bp_ignored_valid", 32'(bus.valid_o), 32'd1);
        check_output("bp_ignored_d", 32'(bus.d_o), 32'h06);
        bus.ready_i = 1'b1;
        idle_cycle();
        check_output("bp_drain_b_d", 32'(bus.d_o), 32'h0A);
        check_output("bp_drain_b_valid", 32'(bus.valid_o), 32'd1);
        check_output("bp_drain_ready", 32'(bus.ready_o), 32'd1);
        idle_cycle();
        check_output("bp_drained_valid", 32'(bus.valid_o), 32'd0);

        // Chain must hold B's upper bits (0x02), not the rejected 0xFF's (0x7F).
        apply_stimulus(RCL, 8'h00, 7'h55, 1'b0, 3'd7);
        check_output("bp_chain_d", 32'(bus.d_o), 32'h02);
        idle_cycle();

        $display("[TB] reset mid-stream");
        bus.ready_i = 1'b0;
        apply_stimulus(LOGIC, 8'h80, 7'h00, 1'b1, 3'd0);
        apply_stimulus(LOGIC, 8'hFF, 7'h00, 1'b1, 3'd0);
        check_output("rst_pre_ready", 32'(bus.ready_o), 32'd0);
        rst_i = 1'b1;
        apply_stimulus(LOGIC, 8'hFF, 7'h00, 1'b1, 3'd0);
        check_output("rst_mid_valid", 32'(bus.valid_o), 32'd0);
        check_output("rst_mid_ready", 32'(bus.ready_o), 32'd1);
        check_output("rst_mid_d", 32'(bus.d_o), 32'd0);
        rst_i       = 1'b0;
        bus.ready_i = 1'b1;
        apply_stimulus(RCL, 8'h01, 7'h7F, 1'b0, 3'd7);
        check_output("rst_chain_d", 32'(bus.d_o), 32'h80);
        check_output("rst_chain_flags", 32'(bus.flags_o), exp_flags(1'b0, 1'b0, 1'b1));
        idle_cycle();
        check_output("final_valid", 32'(bus.valid_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
